// File: rtl/lp_result_bcd.sv
// lp_result_bcd: converts the 8-bit lp_calc_top result into three BCD digits
// using a sequential shift-add-3 (double-dabble) engine. A conversion is only
// started when the incoming value differs from the last converted value (or
// once after reset), so the engine's registers sit idle for a stable input.
module lp_result_bcd (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] result_in,
    output logic [3:0] bcd_hund,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       valid,
    output logic       done,
    output logic       busy,
    output logic [7:0] conv_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_last_val;
    logic        r_pend;
    logic [19:0] r_sh;
    logic [3:0]  r_cnt;

    logic        w_capture;
    logic [19:0] w_sh_adj;
    logic [19:0] w_sh_shift;

    // A new conversion starts from IDLE when forced after reset or when the input moved.
    assign w_capture = (r_state == S_IDLE) && (r_pend || (result_in != r_last_val));

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> SHIFT on capture, 8 shifts, then one DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_capture) w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_cnt == 4'd7) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        busy      = (r_state != S_IDLE);
        dbg_state = r_state;
    end

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        w_sh_adj = r_sh;
        if (r_sh[19:16] >= 4'd5) w_sh_adj[19:16] = r_sh[19:16] + 4'd3;
        if (r_sh[15:12] >= 4'd5) w_sh_adj[15:12] = r_sh[15:12] + 4'd3;
        if (r_sh[11:8]  >= 4'd5) w_sh_adj[11:8]  = r_sh[11:8]  + 4'd3;
        w_sh_shift = {w_sh_adj[18:0], 1'b0};
    end

    // Conversion datapath: only enabled on capture or while shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_val <= 8'd0;
            r_pend     <= 1'b1;
            r_sh       <= 20'd0;
            r_cnt      <= 4'd0;
        end else if (w_capture) begin
            r_last_val <= result_in;
            r_sh       <= {12'd0, result_in};
            r_cnt      <= 4'd0;
            r_pend     <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_sh  <= w_sh_shift;
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // Result registers: digits only change in DONE, so partial results never show.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_hund <= 4'd0;
            bcd_tens <= 4'd0;
            bcd_ones <= 4'd0;
            valid    <= 1'b0;
            done     <= 1'b0;
            conv_cnt <= 8'd0;
        end else begin
            done <= 1'b0;
            if (r_state == S_DONE) begin
                bcd_hund <= r_sh[19:16];
                bcd_tens <= r_sh[15:12];
                bcd_ones <= r_sh[11:8];
                done     <= 1'b1;
                valid    <= 1'b1;
                if (conv_cnt != 8'd255) conv_cnt <= conv_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lp_result_bcd.sv
// Directed testbench for lp_result_bcd.
module tb_lp_result_bcd;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] result_in;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       valid;
    logic       done;
    logic       busy;
    logic [7:0] conv_cnt;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    lp_result_bcd dut (
        .clk       (clk),
        .reset     (reset),
        .result_in (result_in),
        .bcd_hund  (bcd_hund),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .valid     (valid),
        .done      (done),
        .busy      (busy),
        .conv_cnt  (conv_cnt),
        .dbg_state (dbg_state)
    );

    // Clock: 100 MHz.
    always #5 clk = ~clk;

    // Advance one cycle and land 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Tick until done is seen; the bound keeps the bench from hanging.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 40);
    endtask

    task automatic chk_digits(input string tag, input int h, input int t, input int o);
        chk({tag, "_hund"}, 32'(bcd_hund), 32'(h));
        chk({tag, "_tens"}, 32'(bcd_tens), 32'(t));
        chk({tag, "_ones"}, 32'(bcd_ones), 32'(o));
    endtask

    function automatic int next_cnt(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    // Apply a value, expect its conversion 10 cycles later, then hold for 12 cycles total.
    task automatic convert(input string tag, input logic [7:0] v, input int h, input int t, input int o);
        int lat;
        result_in = v;
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd10);
        chk_digits(tag, h, t, o);
        exp_cnt = next_cnt(exp_cnt);
        chk({tag, "_cnt"}, 32'(conv_cnt), 32'(exp_cnt));
        chk({tag, "_hund_le2"}, 32'(bcd_hund <= 4'd2), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int lat;
        int pulses;
        int busy_seen;
        int bad_lat;

        // Reset for two cycles with result_in = 0.
        reset     = 1'b1;
        result_in = 8'd0;
        tick();
        chk("rst_digits_hund", 32'(bcd_hund), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(conv_cnt), 32'd0);
        tick();
        chk_digits("rst2", 0, 0, 0);
        chk("rst2_state", 32'(dbg_state), 32'd0);

        // First conversion is forced even though result_in = 0.
        reset = 1'b0;
        wait_done(lat);
        chk("first_lat", 32'(lat), 32'd10);
        chk_digits("first", 0, 0, 0);
        chk("first_valid", 32'(valid), 32'd1);
        exp_cnt = 1;
        chk("first_cnt", 32'(conv_cnt), 32'd1);
        tick();
        chk("first_done_pulse", 32'(done), 32'd0);
        chk("first_idle_busy", 32'(busy), 32'd0);
        tick();

        // lp_calc_top sequence: 3+2, 7-4, 3*5, 8/2.
        convert("seq5",  8'd5,  0, 0, 5);
        convert("seq3",  8'd3,  0, 0, 3);
        convert("seq15", 8'd15, 0, 1, 5);
        convert("seq4",  8'd4,  0, 0, 4);
        chk("seq_cnt5", 32'(conv_cnt), 32'd5);

        // Boundary values.
        convert("b255", 8'd255, 2, 5, 5);
        convert("b99",  8'd99,  0, 9, 9);
        convert("b100", 8'd100, 1, 0, 0);
        convert("b9",   8'd9,   0, 0, 9);
        convert("b10",  8'd10,  0, 1, 0);
        convert("b199", 8'd199, 1, 9, 9);

        // Change during conversion: 15, then 200 three cycles later.
        result_in = 8'd15;
        tick();
        chk("chg_busy", 32'(busy), 32'd1);
        tick();
        tick();
        result_in = 8'd200;
        pulses = 0;
        wait_done(lat);
        if (done) pulses++;
        chk("chg_first_lat", 32'(lat), 32'd7);
        chk_digits("chg_first", 0, 1, 5);
        wait_done(lat);
        if (done) pulses++;
        chk("chg_second_lat", 32'(lat), 32'd10);
        chk_digits("chg_second", 2, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("chg_pulses", 32'(pulses), 32'd2);
        exp_cnt = next_cnt(next_cnt(exp_cnt));
        chk("chg_cnt", 32'(conv_cnt), 32'(exp_cnt));

        // Stable input: one conversion, then nothing for 100 cycles.
        convert("hold42", 8'd42, 0, 4, 2);
        pulses    = 0;
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) pulses++;
            if (busy) busy_seen = 1;
        end
        chk("hold_pulses", 32'(pulses), 32'd0);
        chk("hold_busy", 32'(busy_seen), 32'd0);
        chk("hold_cnt", 32'(conv_cnt), 32'(exp_cnt));
        chk_digits("hold", 0, 4, 2);

        // Reset on the 4th SHIFT cycle of a conversion of 128.
        result_in = 8'd128;
        tick();
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_state_shift", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        tick();
        if (done) pulses++;
        chk_digits("abort", 0, 0, 0);
        chk("abort_valid", 32'(valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cnt", 32'(conv_cnt), 32'd0);
        tick();
        if (done) pulses++;
        chk("abort_pulses", 32'(pulses), 32'd0);
        reset = 1'b0;
        wait_done(lat);
        chk("rel128_lat", 32'(lat), 32'd10);
        chk_digits("rel128", 1, 2, 8);
        chk("rel128_cnt", 32'(conv_cnt), 32'd1);
        exp_cnt = 1;
        tick();

        // Saturation of the conversion counter.
        bad_lat = 0;
        for (int i = 0; i < 260; i++) begin
            result_in = (i % 2 == 1) ? 8'd7 : 8'd8;
            wait_done(lat);
            if (lat != 10) bad_lat++;
            exp_cnt = next_cnt(exp_cnt);
        end
        chk("sat_lat", 32'(bad_lat), 32'd0);
        chk("sat_cnt", 32'(conv_cnt), 32'(exp_cnt));
        chk("sat_cnt255", 32'(conv_cnt), 32'd255);
        chk_digits("sat", 0, 0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
